// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES signed logits, one candidate per cycle.
// Optional top-1/top-2 margin output enabled by defining ARGMAX_MARGIN_EN.
module argmax_classifier #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAC_BITS   = 7,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDXW        = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] logits [0:NUM_CLASSES-1],
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic        [IDXW-1:0]       class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic        [DATA_WIDTH:0]   margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  localparam logic [IDXW-1:0] K_LAST = IDXW'(NUM_CLASSES - 1);

  state_t                      state_q, state_d;
  logic signed [DATA_WIDTH-1:0] logit_buf_q [0:NUM_CLASSES-1];
  logic signed [DATA_WIDTH-1:0] best_q;
  logic        [IDXW-1:0]       best_idx_q;
  logic        [IDXW-1:0]       k_q;
  logic        [IDXW-1:0]       class_idx_q;
  logic signed [DATA_WIDTH-1:0] max_val_q;
  logic                         done_q;
  logic                         valid_q;
  logic signed [DATA_WIDTH-1:0] x;
  logic                         take_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (NUM_CLASSES == 1) ? FINISH : SCAN;
      SCAN:    if (k_q == K_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mux by comparison rather than direct indexing keeps the 1-class build width-clean.
  always_comb begin
    x = logit_buf_q[0];
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (k_q == IDXW'(i)) x = logit_buf_q[i];
    end
  end

  assign take_x = (x > best_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      logit_buf_q <= '{default: '0};
      best_q      <= '0;
      best_idx_q  <= '0;
      k_q         <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            logit_buf_q <= logits;
            best_q      <= logits[0];
            best_idx_q  <= '0;
            k_q         <= IDXW'(1);
          end
        end
        SCAN: begin
          if (take_x) begin
            best_q     <= x;
            best_idx_q <= k_q;
          end
          if (k_q != K_LAST) k_q <= k_q + IDXW'(1);
        end
        FINISH: begin
          class_idx_q <= best_idx_q;
          max_val_q   <= best_q;
          done_q      <= 1'b1;
          valid_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] second_q;
  logic        [DATA_WIDTH:0]   margin_q;
  logic        [DATA_WIDTH:0]   diff;
  logic        [DATA_WIDTH:0]   margin_d;

  // Sign-extend both operands so the full signed range difference fits unsigned.
  assign diff     = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
  assign margin_d = (NUM_CLASSES == 1) ? '0 : diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      second_q <= '0;
      margin_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:   if (start) second_q <= S_MIN;
        SCAN: begin
          if (take_x)             second_q <= best_q;
          else if (x > second_q)  second_q <= x;
        end
        FINISH: margin_q <= margin_d;
        default: ;
      endcase
    end
  end

  assign margin = margin_q;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign valid     = valid_q;
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;

endmodule
